// File: rtl/imm_pkg.sv
// rtl/imm_pkg.sv - immediate type codes shared by the decoder, FIFO and bench
package imm_pkg;

    typedef logic [2:0] imm_type_t;

    localparam imm_type_t IMM_I     = 3'b000;
    localparam imm_type_t IMM_B     = 3'b001;
    localparam imm_type_t IMM_S     = 3'b010;
    localparam imm_type_t IMM_U     = 3'b011;
    localparam imm_type_t IMM_J     = 3'b100;
    localparam imm_type_t IMM_SHAMT = 3'b101;
    localparam imm_type_t IMM_Z     = 3'b110;
    localparam imm_type_t IMM_BAD   = 3'b111;

endpackage

// File: rtl/imm_decode.sv
// rtl/imm_decode.sv - combinational immediate extraction; Z-type gated by IMM_GEN_FIFO_ZICSR_EN
module imm_decode
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]      instr,
    input  logic [2:0]       imm_type,
    output logic [XLEN-1:0]  imm,
    output logic             bad
);

    // Every type is first formed as a 32-bit value; zero-extended types
    // always have bit 31 clear, so one sign-extension step covers all.
    logic [31:0] v32;

    // opcode bits never contribute to an immediate
    logic unused_opcode;
    assign unused_opcode = ^instr[6:0];

    // select and assemble the immediate fields for the requested type
    always_comb begin
        v32 = '0;
        bad = 1'b0;
        case (imm_type)
            IMM_I:     v32 = {{20{instr[31]}}, instr[31:20]};
            IMM_B:     v32 = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_S:     v32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_U:     v32 = {instr[31:12], 12'b0};
            IMM_J:     v32 = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            IMM_SHAMT: begin
                if (XLEN == 64) v32 = {26'b0, instr[25:20]};
                else            v32 = {27'b0, instr[24:20]};
            end
`ifdef IMM_GEN_FIFO_ZICSR_EN
            IMM_Z:     v32 = {27'b0, instr[19:15]};
`endif
            default:   bad = 1'b1;
        endcase
    end

    generate
        if (XLEN == 64) begin : g_x64
            assign imm = {{(XLEN-32){v32[31]}}, v32};
        end else begin : g_x32
            assign imm = v32;
        end
    endgenerate

endmodule

// File: rtl/imm_gen_fifo.sv
// rtl/imm_gen_fifo.sv - buffered immediate generator; option macro IMM_GEN_FIFO_ZICSR_EN
module imm_gen_fifo
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2,
    parameter int TAG_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [2:0]        in_imm_type,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_imm,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_bad
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [XLEN-1:0]  imm_mem [DEPTH];
    logic [TAG_W-1:0] tag_mem [DEPTH];
    logic             bad_mem [DEPTH];

    logic [PTR_W-1:0] head_ptr;
    logic [PTR_W-1:0] tail_ptr;
    logic [CNT_W-1:0] count;

    logic [XLEN-1:0]  dec_imm;
    logic             dec_bad;
    logic             full;
    logic             push;
    logic             pop;

    imm_decode #(
        .XLEN (XLEN)
    ) u_decode (
        .instr    (in_instr),
        .imm_type (in_imm_type),
        .imm      (dec_imm),
        .bad      (dec_bad)
    );

    // Ready is a function of occupancy only, so no combinational path
    // runs from out_ready back to in_ready.
    assign full      = (count == CNT_W'(DEPTH));
    assign in_ready  = !full && !rst;
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // pointer and occupancy bookkeeping; flush and reset drop everything
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            if (push) tail_ptr <= tail_ptr + PTR_W'(1);
            if (pop)  head_ptr <= head_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // capture the decoded immediate, tag and illegal flag at push time
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            imm_mem[tail_ptr] <= dec_imm;
            tag_mem[tail_ptr] <= in_tag;
            bad_mem[tail_ptr] <= dec_bad;
        end
    end

    // head fields are masked to zero whenever nothing is queued
    always_comb begin
        out_imm = '0;
        out_tag = '0;
        out_bad = 1'b0;
        if (out_valid) begin
            out_imm = imm_mem[head_ptr];
            out_tag = tag_mem[head_ptr];
            out_bad = bad_mem[head_ptr];
        end
    end

endmodule

// File: doc/imm_gen_fifo.md
# imm_gen_fifo

Buffered, parametrised immediate generator for the decode stage. It accepts an instruction word, immediate type and tag under a valid/ready handshake, and computes the sign- or zero-extended immediate at `XLEN` width. Results are queued in an in-order FIFO of `DEPTH` entries, so fetch and execute decouple without a combinational ready path. The block replaces the bare combinational immediate extraction path between fetch and execute.

## Interface

Parameters:
- `XLEN`, default 32: datapath width; legal values are 32 or 64.
- `DEPTH`, default 2: FIFO entries; a power of 2 and ≥ 2.
- `TAG_W`, default 32: width of the pass-through tag (typically the PC).

Ports:
- `clk`, in, 1: the single clock; all state updates on its rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `flush`, in, 1: synchronous discard of all queued entries.
- `in_valid`, in, 1: an input item is offered.
- `in_ready`, out, 1: the block can accept an item this cycle.
- `in_instr`, in, 32: raw instruction word.
- `in_imm_type`, in, 3: immediate type select.
- `in_tag`, in, `TAG_W`: carried unchanged to the output.
- `out_valid`, out, 1: the FIFO head holds a result.
- `out_ready`, in, 1: the consumer takes the head this cycle.
- `out_imm`, out, `XLEN`: immediate at the FIFO head.
- `out_tag`, out, `TAG_W`: tag at the FIFO head.
- `out_bad`, out, 1: the head entry had an illegal `imm_type`.

## Operation

- A push happens when `in_valid && in_ready`. A pop happens when `out_valid && out_ready`.
- The immediate is computed combinationally from `in_instr`/`in_imm_type` and stored at push time. The stored values are `{imm, tag, bad}`.
- Immediate type encodings (sext = sign-extend to `XLEN`):
  - 000 I: sext(`instr[31:20]`).
  - 001 B: sext({`[31]`,`[7]`,`[30:25]`,`[11:8]`,0}).
  - 010 S: sext({`[31:25]`,`[11:7]`}).
  - 011 U: sext({`[31:12]`,12'b0}). For `XLEN`=64, bit 31 replicates into the upper bits.
  - 100 J: sext({`[31]`,`[19:12]`,`[20]`,`[30:21]`,0}).
  - 101 shamt: zero-extended `instr[24:20]` when `XLEN`=32, `instr[25:20]` when `XLEN`=64.
  - 110 Z (CSR uimm): zero-extended `instr[19:15]`. Available only with the configuration macro; otherwise it is treated as illegal.
  - 111, and 110 when not configured, are illegal: imm = 0, bad = 1.
- `in_ready` = !full && !rst. It depends only on the occupancy count, never on `out_ready`.
- The FIFO has a head pointer, a tail pointer and a count of `$clog2(DEPTH)+1` bits. The pointers wrap modulo `DEPTH`.
- When occupancy is 0 < count < `DEPTH`, a push and a pop in the same cycle both occur and the count is unchanged.
- When full, a push cannot happen (`in_ready`=0). A pop frees the slot, and `in_ready` reasserts on the next cycle.
- `flush` sets pointers and count to 0. It dominates a same-cycle push and pop: the offered item is dropped and not accepted.
- `out_imm`, `out_tag` and `out_bad` are forced to 0 whenever `out_valid`=0.

## Timing

- Reset: count and pointers are 0. `out_valid`=0 and `out_imm`/`out_tag`/`out_bad`=0. `in_ready`=0 while `rst` is high, then 1 from the first cycle after `rst` falls.
- Reset asserted mid-operation discards all entries at the next edge, identical to `flush`.
- Latency: an item pushed at edge N appears at the output (`out_valid`=1) in the cycle after edge N, if the FIFO was empty.
- Throughput: one item per cycle, sustained while `out_ready`=1.
- Ordering: strict FIFO; no reordering.

## Configuration

- `IMM_GEN_FIFO_ZICSR_EN` defined: type 110 yields the zero-extended `instr[19:15]` with `out_bad`=0.
- `IMM_GEN_FIFO_ZICSR_EN` undefined: type 110 is illegal, giving imm = 0 and `out_bad`=1. No Z-type logic is synthesised.

## Structure

- `imm_pkg` holds:
  - localparams `IMM_I`, `IMM_B`, `IMM_S`, `IMM_U`, `IMM_J`, `IMM_SHAMT`, `IMM_Z`, `IMM_BAD` (3-bit codes);
  - the `imm_type_t` typedef.
- Sub-module `imm_decode` is purely combinational: inputs `instr`, `imm_type`; outputs `imm[XLEN-1:0]`, `bad`; parameter `XLEN`.
- The top level `imm_gen_fifo` instantiates `imm_decode` and owns the FIFO storage and control.

## Test plan

- I-type: `XLEN`=32, `in_instr`=0xFFF00093, type 000, push into an empty FIFO → next cycle `out_valid`=1, `out_imm`=0xFFFFFFFF, `out_bad`=0.
- B-type: `in_instr`=0xFE000EE3, type 001 → `out_imm`=0xFFFFFFFC. Tag 0x00000100 is returned unchanged.
- Backpressure: `DEPTH`=2, `out_ready`=0, offer 3 items every cycle → `in_ready` falls after 2 accepts and the third item is held off. With `out_ready`=1, the items drain in push order and `in_ready` returns 1 cycle after the first pop.
- `XLEN`=64:
  - U-type 0x800000B7 → `out_imm`=0xFFFFFFFF80000000.
  - shamt with `instr[25:20]`=63 → `out_imm`=63.
- Flush: with 1 entry queued, assert `flush` together with a valid push → the next cycle has `out_valid`=0 and count 0, and the pushed item never appears.
- Z-type: `in_instr`=0x0001D073, type 110.
  - With `IMM_GEN_FIFO_ZICSR_EN`: `out_imm`=3, `out_bad`=0.
  - Without it: `out_imm`=0, `out_bad`=1.
  - Type 111 in either build → `out_bad`=1.
